// File: rtl/cbfp_block_norm.sv
// Block floating point normaliser: buffers BLOCK_BEATS beats in a ping-pong store, then replays
// them shifted by one common block exponent. Define CBFP_ROUND_EN for round-half-up right shifts.
module cbfp_block_norm #(
   parameter int LANES       = 16,
   parameter int IN_W        = 16,
   parameter int OUT_W       = 13,
   parameter int BLOCK_BEATS = 4,
   parameter int EXP_W       = $clog2(IN_W) + 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    valid_in,
   input  logic signed [IN_W-1:0]  data_re_in  [0:LANES-1],
   input  logic signed [IN_W-1:0]  data_im_in  [0:LANES-1],
   output logic                    valid_out,
   output logic                    sop_out,
   output logic                    eop_out,
   output logic signed [OUT_W-1:0] data_re_out [0:LANES-1],
   output logic signed [OUT_W-1:0] data_im_out [0:LANES-1],
   output logic signed [EXP_W-1:0] exp_out
);

   localparam int CW = $clog2(BLOCK_BEATS);
   localparam int WW = IN_W + OUT_W + 1;
   localparam logic [CW-1:0]           LAST    = CW'(BLOCK_BEATS - 1);
   localparam logic [EXP_W-1:0]        HR_MAX  = EXP_W'(IN_W - 1);
   localparam logic signed [EXP_W-1:0] GAIN    = EXP_W'(IN_W - OUT_W);
   localparam logic signed [WW-1:0]    SAT_MAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [WW-1:0]    SAT_MIN = ~SAT_MAX;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

   function automatic logic [EXP_W-1:0] f_hr(input logic [IN_W-1:0] x);
      logic [EXP_W-1:0] n;
      logic             run;
      n   = '0;
      run = 1'b1;
      for (int i = IN_W - 2; i >= 0; i--) begin
         if (run && (x[i] == x[IN_W-1])) n = n + EXP_W'(1);
         else                            run = 1'b0;
      end
      return n;
   endfunction

   function automatic logic signed [OUT_W-1:0] f_norm(input logic signed [IN_W-1:0]  x,
                                                      input logic signed [EXP_W-1:0] s);
      logic signed [WW-1:0] t;
      logic [EXP_W-1:0]     sh;
      t = {{(WW-IN_W){x[IN_W-1]}}, x};
      if (s[EXP_W-1] == 1'b0) begin
         sh = s;
         t  = t <<< sh;
      end else begin
         sh = -s;
`ifdef CBFP_ROUND_EN
         t  = t + (WW'(1) <<< (sh - EXP_W'(1)));
`endif
         t  = t >>> sh;
      end
      if (t > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
      else if (t < SAT_MIN) return SAT_MIN[OUT_W-1:0];
      else                  return t[OUT_W-1:0];
   endfunction

   logic signed [IN_W-1:0]  r_mem_re [0:1][0:BLOCK_BEATS-1][0:LANES-1];
   logic signed [IN_W-1:0]  r_mem_im [0:1][0:BLOCK_BEATS-1][0:LANES-1];
   logic [CW-1:0]           r_wcnt, r_rcnt;
   logic                    r_wbank, r_rbank;
   logic [EXP_W-1:0]        r_runmin;
   logic signed [EXP_W-1:0] r_exp [0:1];
   logic [1:0]              r_full;
   state_t                  r_state;

   logic [EXP_W-1:0]        w_beat_min, w_hmin;
   logic                    w_wlast, w_rd_en, w_rd_last;
   logic [1:0]              w_full_nxt;
   state_t                  w_next_state;
   logic signed [OUT_W-1:0] w_norm_re [0:LANES-1];
   logic signed [OUT_W-1:0] w_norm_im [0:LANES-1];

   // Headroom of the incoming beat folded into the block running minimum
   always_comb begin
      w_beat_min = HR_MAX;
      for (int l = 0; l < LANES; l++) begin
         w_beat_min = (f_hr(data_re_in[l]) < w_beat_min) ? f_hr(data_re_in[l]) : w_beat_min;
         w_beat_min = (f_hr(data_im_in[l]) < w_beat_min) ? f_hr(data_im_in[l]) : w_beat_min;
      end
      w_hmin  = (r_wcnt == '0) ? w_beat_min :
                ((r_runmin < w_beat_min) ? r_runmin : w_beat_min);
      w_wlast = valid_in && (r_wcnt == LAST);
   end

   // Sample storage; contents are qualified by r_full so no reset is needed
   always_ff @(posedge clk) begin
      if (valid_in) begin
         for (int l = 0; l < LANES; l++) begin
            r_mem_re[r_wbank][r_wcnt][l] <= data_re_in[l];
            r_mem_im[r_wbank][r_wcnt][l] <= data_im_in[l];
         end
      end
   end

   // Write side: beat counter, running minimum, per-bank exponent and bank pointer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wcnt   <= '0;
         r_wbank  <= 1'b0;
         r_runmin <= HR_MAX;
         r_exp[0] <= '0;
         r_exp[1] <= '0;
      end else if (w_wlast) begin
         r_exp[r_wbank] <= signed'(w_hmin) - GAIN;
         r_wbank        <= ~r_wbank;
         r_wcnt         <= '0;
         r_runmin       <= HR_MAX;
      end else if (valid_in) begin
         r_runmin <= w_hmin;
         r_wcnt   <= r_wcnt + CW'(1);
      end
   end

   // Read FSM next state; a bank filled while the other is draining is picked up with no gap
   always_comb begin
      w_next_state = r_state;
      w_rd_en      = 1'b0;
      w_rd_last    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_full[r_rbank]) w_next_state = S_READ;
            else                 w_next_state = S_IDLE;
         end
         S_READ: begin
            w_rd_en = 1'b1;
            if (r_rcnt == LAST) begin
               w_rd_last    = 1'b1;
               w_next_state = r_full[~r_rbank] ? S_READ : S_IDLE;
            end else begin
               w_next_state = S_READ;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      w_full_nxt = r_full;
      if (w_rd_last) w_full_nxt[r_rbank] = 1'b0;
      else           w_full_nxt = w_full_nxt;
      if (w_wlast)   w_full_nxt[r_wbank] = 1'b1;
      else           w_full_nxt = w_full_nxt;
   end

   // Read side state: FSM, read counter, bank pointer, full flags
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_rcnt  <= '0;
         r_rbank <= 1'b0;
         r_full  <= '0;
      end else begin
         r_state <= w_next_state;
         r_full  <= w_full_nxt;
         if (w_rd_last)    r_rcnt <= '0;
         else if (w_rd_en) r_rcnt <= r_rcnt + CW'(1);
         if (w_rd_last)    r_rbank <= ~r_rbank;
      end
   end

   // Shift the addressed beat by the stored block exponent
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_norm_re[l] = f_norm(r_mem_re[r_rbank][r_rcnt][l], r_exp[r_rbank]);
         w_norm_im[l] = f_norm(r_mem_im[r_rbank][r_rcnt][l], r_exp[r_rbank]);
      end
   end

   // Output registers; data and exponent hold between blocks, framing flags only with valid
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_out <= 1'b0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
         exp_out   <= '0;
         for (int l = 0; l < LANES; l++) begin
            data_re_out[l] <= '0;
            data_im_out[l] <= '0;
         end
      end else if (w_rd_en) begin
         valid_out <= 1'b1;
         sop_out   <= (r_rcnt == '0);
         eop_out   <= w_rd_last;
         exp_out   <= r_exp[r_rbank];
         for (int l = 0; l < LANES; l++) begin
            data_re_out[l] <= w_norm_re[l];
            data_im_out[l] <= w_norm_im[l];
         end
      end else begin
         valid_out <= 1'b0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Directed bench for cbfp_block_norm: table of block patterns with hand-computed exponents and
// outputs, plus back-to-back, gapped-input and mid-block reset sequences.
module tb_cbfp_block_norm;

   logic                clk = 1'b0;
   logic                rstn, valid_in;
   logic signed [15:0]  din_re [0:15];
   logic signed [15:0]  din_im [0:15];
   logic                valid_out, sop_out, eop_out;
   logic signed [12:0]  dout_re [0:15];
   logic signed [12:0]  dout_im [0:15];
   logic signed [4:0]   exp_out;

   cbfp_block_norm dut (
      .clk(clk), .rstn(rstn), .valid_in(valid_in),
      .data_re_in(din_re), .data_im_in(din_im),
      .valid_out(valid_out), .sop_out(sop_out), .eop_out(eop_out),
      .data_re_out(dout_re), .data_im_out(dout_im), .exp_out(exp_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // One block: every sample = base except one (beat, lane, re/im) = spec.
   typedef struct { int base; int spec; int exp; int base_out; int spec_out; } vec_t;
   typedef struct { int v; int b; } beat_t;
   vec_t  tbl [0:7];
   beat_t q [$];

   int n_tests = 0, n_fail = 0;
   int sop_cyc, max_run = 0, run = 0, n_beats = 0;
   bit prev_v = 1'b0;

   function automatic bit is_spec(int v, int b, int l, int part);
      return (b == v % 4) && (l == (v * 5) % 16) && (part == v % 2);
   endfunction

   function automatic int stim_val(int v, int b, int l, int part);
      return is_spec(v, b, l, part) ? tbl[v].spec : tbl[v].base;
   endfunction

   function automatic int exp_val(int v, int b, int l, int part);
      return is_spec(v, b, l, part) ? tbl[v].spec_out : tbl[v].base_out;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic check_reset_zero(input string name);
      int nz;
      nz = int'(valid_out) + int'(sop_out) + int'(eop_out) + ((exp_out != 5'sd0) ? 1 : 0);
      for (int l = 0; l < 16; l++)
         nz += ((dout_re[l] != 13'sd0) ? 1 : 0) + ((dout_im[l] != 13'sd0) ? 1 : 0);
      check(name, nz, 0);
   endtask

   task automatic monitor();
      beat_t e;
      int    bad, bad_l, act, req;
      bit    ok;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_v = 1'b0;
            run    = 0;
         end else begin
            if (valid_out) begin
               n_beats++;
               run = prev_v ? run + 1 : 1;
               if (run > max_run) max_run = run;
               if (sop_out) sop_cyc = cyc;
               n_tests++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_beat: got beat with exp=%0d sop=%0d, required no beat",
                           exp_out, sop_out);
               end else begin
                  e = q.pop_front();
                  bad = 0; bad_l = -1; act = 0; req = 0;
                  for (int l = 0; l < 16; l++) begin
                     if (int'(dout_re[l]) != exp_val(e.v, e.b, l, 0)) begin
                        bad++;
                        if (bad_l < 0) begin bad_l = l; act = int'(dout_re[l]); req = exp_val(e.v, e.b, l, 0); end
                     end
                     if (int'(dout_im[l]) != exp_val(e.v, e.b, l, 1)) begin
                        bad++;
                        if (bad_l < 0) begin bad_l = l; act = int'(dout_im[l]); req = exp_val(e.v, e.b, l, 1); end
                     end
                  end
                  ok = (bad == 0) && (int'(exp_out) == tbl[e.v].exp) &&
                       (sop_out == (e.b == 0)) && (eop_out == (e.b == 3)) && (e.b == 0 || prev_v);
                  if (!ok) begin
                     n_fail++;
                     $display("FAIL beat v%0d b%0d: got exp=%0d sop=%0d eop=%0d prev_valid=%0d bad=%0d lane%0d=%0d, required exp=%0d sop=%0d eop=%0d contiguous lane=%0d",
                              e.v, e.b, exp_out, sop_out, eop_out, prev_v, bad, bad_l, act,
                              tbl[e.v].exp, (e.b == 0), (e.b == 3), req);
                  end
               end
            end
            prev_v = valid_out;
         end
      end
   endtask

   task automatic send_block(input int v, input int nb, input bit gap, input bit push,
                             output int in_c);
      in_c = 0;
      for (int b = 0; b < nb; b++) begin
         if (push) q.push_back('{v: v, b: b});
         @(negedge clk);
         for (int l = 0; l < 16; l++) begin
            din_re[l] = 16'(stim_val(v, b, l, 0));
            din_im[l] = 16'(stim_val(v, b, l, 1));
         end
         valid_in = 1'b1;
         in_c = cyc + 1;
         if (gap && b < nb - 1) begin
            @(negedge clk);
            valid_in = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int in_c, b0, b1, b2, b3;
      tbl[0] = '{16,     16,     7,  2048,  2048};
      tbl[1] = '{1,      32767,  -3, 0,     4095};
`ifdef CBFP_ROUND_EN
      tbl[2] = '{4,      32767,  -3, 1,     4095};
`else
      tbl[2] = '{4,      32767,  -3, 0,     4095};
`endif
      tbl[3] = '{0,      -32768, -3, 0,     -4096};
      tbl[4] = '{0,      0,      12, 0,     0};
      tbl[5] = '{-1,     100,    5,  -32,   3200};
      tbl[6] = '{-300,   1000,   2,  -1200, 4000};
`ifdef CBFP_ROUND_EN
      tbl[7] = '{4096,   -5,     -1, 2048,  -2};
`else
      tbl[7] = '{4096,   -5,     -1, 2048,  -3};
`endif
      rstn = 1'b0;
      valid_in = 1'b0;
      for (int l = 0; l < 16; l++) begin
         din_re[l] = 16'sd0;
         din_im[l] = 16'sd0;
      end
      fork monitor(); join_none
      repeat (3) @(negedge clk);
      check_reset_zero("reset_state");
      rstn = 1'b1;

      // Each table entry as an isolated block; latency measured on every one
      for (int v = 0; v < 8; v++) begin
         sop_cyc = -1;
         send_block(v, 4, 1'b0, 1'b1, in_c);
         idle(6);
         check($sformatf("latency_v%0d", v), sop_cyc - in_c, 2);
      end

      // Three blocks with continuous valid_in
      max_run = 0;
      send_block(1, 4, 1'b0, 1'b1, in_c);
      send_block(6, 4, 1'b0, 1'b1, in_c);
      send_block(7, 4, 1'b0, 1'b1, in_c);
      idle(20);
      check("b2b_run", max_run, 12);

      // Gapped input still yields one contiguous 4-beat block
      max_run = 0;
      sop_cyc = -1;
      send_block(6, 4, 1'b1, 1'b1, in_c);
      idle(10);
      check("gap_run", max_run, 4);
      check("gap_latency", sop_cyc - in_c, 2);

      // Reset right after a complete block: buffered block must vanish
      send_block(2, 4, 1'b0, 1'b0, in_c);
      @(negedge clk);
      valid_in = 1'b0;
      rstn = 1'b0;
      #1;
      check_reset_zero("reset_zero_buffered");
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      idle(6);

      // Reset after two beats, then one fresh block
      b0 = n_beats;
      send_block(3, 2, 1'b0, 1'b0, in_c);
      @(negedge clk);
      valid_in = 1'b0;
      rstn = 1'b0;
      #1;
      check_reset_zero("reset_zero_partial");
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      send_block(5, 4, 1'b0, 1'b1, in_c);
      idle(10);
      check("post_reset_beats", n_beats - b0, 4);

      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      check("drain_pending", q.size(), 0);
      b1 = 0; b2 = 0; b3 = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
